// File: rtl/uart_stream_pkg.sv
// rtl/uart_stream_pkg.sv - shared types and constants for the UART stream adapter
// Contents: FSM state enum, guard counter width, error-flag struct, saturating increment helper.
package uart_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        GUARD
    } state_t;

    localparam int GUARD_CNT_W = 3;

    typedef struct packed {
        logic perr;
        logic ferr;
        logic ovf;
    } err_flags_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_stream_errcnt.sv
// rtl/uart_stream_errcnt.sv - saturating parity/framing/overflow error counters
// Ports: CLK, aresetn (async active-low), capture (RD capture strobe),
//        flags_bits {perr, ferr, ovf} sampled with the capture, clr (sync clear),
//        perr_cnt/ferr_cnt/ovf_cnt 8-bit saturating counts.
module uart_stream_errcnt
    import uart_stream_pkg::*;
(
    input  logic       CLK,
    input  logic       aresetn,
    input  logic       capture,
    input  logic [2:0] flags_bits,
    input  logic       clr,
    output logic [7:0] perr_cnt,
    output logic [7:0] ferr_cnt,
    output logic [7:0] ovf_cnt
);

    err_flags_t flags;
    assign flags = flags_bits;

    always_ff @(posedge CLK or negedge aresetn) begin
        if (!aresetn) begin
            perr_cnt <= 8'd0;
            ferr_cnt <= 8'd0;
            ovf_cnt  <= 8'd0;
        end else if (clr) begin
            // Clear takes precedence over an increment in the same cycle.
            perr_cnt <= 8'd0;
            ferr_cnt <= 8'd0;
            ovf_cnt  <= 8'd0;
        end else if (capture) begin
            if (flags.perr) perr_cnt <= sat_inc8(perr_cnt);
            if (flags.ferr) ferr_cnt <= sat_inc8(ferr_cnt);
            if (flags.ovf)  ovf_cnt  <= sat_inc8(ovf_cnt);
        end
    end

endmodule

// File: rtl/uart_stream_adapter.sv
// rtl/uart_stream_adapter.sv - valid/ready byte stream front end for the strobe-style UART core
// Ports: CLK, aresetn (async active-low);
//        s_tx_* byte stream in, m_rx_* byte stream out with per-byte error flags;
//        uart_csn/wen/oen/data_in to the core, uart_data_out/txrdy/rxrdy/error flags from the core.
// Option: UART_STREAM_ERRCNT_EN adds err_cnt_clr and perr_cnt/ferr_cnt/ovf_cnt.
module uart_stream_adapter
    import uart_stream_pkg::*;
#(
    parameter int GUARD_CYCLES = 2,
    parameter bit RR_ARB       = 1'b1
) (
    input  logic       CLK,
    input  logic       aresetn,
    input  logic [7:0] s_tx_data,
    input  logic       s_tx_valid,
    output logic       s_tx_ready,
    output logic [7:0] m_rx_data,
    output logic       m_rx_perr,
    output logic       m_rx_ferr,
    output logic       m_rx_ovf,
    output logic       m_rx_valid,
    input  logic       m_rx_ready,
    output logic       uart_csn,
    output logic       uart_wen,
    output logic       uart_oen,
    output logic [7:0] uart_data_in,
    input  logic [7:0] uart_data_out,
    input  logic       uart_txrdy,
    input  logic       uart_rxrdy,
    input  logic       uart_parity_err,
    input  logic       uart_framing_err,
    input  logic       uart_overflow
`ifdef UART_STREAM_ERRCNT_EN
    ,
    input  logic       err_cnt_clr,
    output logic [7:0] perr_cnt,
    output logic [7:0] ferr_cnt,
    output logic [7:0] ovf_cnt
`endif
);

    state_t                 state;
    logic [GUARD_CNT_W-1:0] guard_cnt;
    logic                   arb_ptr_rx;   // 0: write wins next contention, 1: read wins
    logic                   tx_full;
    logic [7:0]             tx_hold;

    logic tx_load;
    logic tx_full_nxt;
    logic wr_req;
    logic rd_req;
    logic grant_wr;
    logic grant_rd;
    logic decide;

    assign tx_load     = s_tx_valid & s_tx_ready;
    // A byte accepted in the strobe cycle refills the holding register.
    assign tx_full_nxt = tx_load ? 1'b1 : ((state == WR) ? 1'b0 : tx_full);

    assign wr_req = tx_full & uart_txrdy;
    assign rd_req = uart_rxrdy & (~m_rx_valid | m_rx_ready);

    // The next strobe is decided in the last guard cycle so that back-to-back
    // transfers are GUARD_CYCLES+1 cycles apart; IDLE also decides.
    assign decide = (state == IDLE) ||
                    ((state == GUARD) && (guard_cnt == GUARD_CNT_W'(GUARD_CYCLES - 1)));

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (wr_req && rd_req) begin
            if (RR_ARB && !arb_ptr_rx) grant_wr = 1'b1;
            else                       grant_rd = 1'b1;
        end else if (wr_req) begin
            grant_wr = 1'b1;
        end else if (rd_req) begin
            grant_rd = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge aresetn) begin
        if (!aresetn) begin
            tx_full    <= 1'b0;
            tx_hold    <= 8'd0;
            s_tx_ready <= 1'b1;
        end else begin
            tx_full    <= tx_full_nxt;
            s_tx_ready <= ~tx_full_nxt;
            if (tx_load) tx_hold <= s_tx_data;
        end
    end

    always_ff @(posedge CLK or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            guard_cnt    <= '0;
            arb_ptr_rx   <= 1'b0;
            uart_csn     <= 1'b1;
            uart_wen     <= 1'b1;
            uart_oen     <= 1'b1;
            uart_data_in <= 8'd0;
            m_rx_valid   <= 1'b0;
            m_rx_data    <= 8'd0;
            m_rx_perr    <= 1'b0;
            m_rx_ferr    <= 1'b0;
            m_rx_ovf     <= 1'b0;
        end else begin
            uart_csn <= 1'b1;
            uart_wen <= 1'b1;
            uart_oen <= 1'b1;

            if (m_rx_valid && m_rx_ready) m_rx_valid <= 1'b0;

            case (state)
                IDLE, GUARD: begin
                    guard_cnt <= guard_cnt + GUARD_CNT_W'(1);
                    if (decide) begin
                        guard_cnt <= '0;
                        if (grant_wr) begin
                            state        <= WR;
                            uart_csn     <= 1'b0;
                            uart_wen     <= 1'b0;
                            uart_data_in <= tx_hold;
                            arb_ptr_rx   <= 1'b1;
                        end else if (grant_rd) begin
                            state      <= RD;
                            uart_csn   <= 1'b0;
                            uart_oen   <= 1'b0;
                            arb_ptr_rx <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                WR: begin
                    state     <= GUARD;
                    guard_cnt <= '0;
                end
                RD: begin
                    state      <= GUARD;
                    guard_cnt  <= '0;
                    m_rx_data  <= uart_data_out;
                    m_rx_perr  <= uart_parity_err;
                    m_rx_ferr  <= uart_framing_err;
                    m_rx_ovf   <= uart_overflow;
                    m_rx_valid <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    guard_cnt <= '0;
                end
            endcase
        end
    end

`ifdef UART_STREAM_ERRCNT_EN
    err_flags_t cur_flags;
    assign cur_flags = '{perr: uart_parity_err, ferr: uart_framing_err, ovf: uart_overflow};

    uart_stream_errcnt u_errcnt (
        .CLK        (CLK),
        .aresetn    (aresetn),
        .capture    (state == RD),
        .flags_bits (cur_flags),
        .clr        (err_cnt_clr),
        .perr_cnt   (perr_cnt),
        .ferr_cnt   (ferr_cnt),
        .ovf_cnt    (ovf_cnt)
    );
`endif

endmodule

// File: tb/tb_uart_stream_adapter.sv
// tb/tb_uart_stream_adapter.sv - directed self-checking bench for uart_stream_adapter
module tb_uart_stream_adapter;

    logic       CLK = 1'b0;
    logic       aresetn;
    logic [7:0] s_tx_data;
    logic       s_tx_valid;
    logic       s_tx_ready;
    logic [7:0] m_rx_data;
    logic       m_rx_perr;
    logic       m_rx_ferr;
    logic       m_rx_ovf;
    logic       m_rx_valid;
    logic       m_rx_ready;
    logic       uart_csn;
    logic       uart_wen;
    logic       uart_oen;
    logic [7:0] uart_data_in;
    logic [7:0] uart_data_out;
    logic       uart_txrdy;
    logic       uart_rxrdy;
    logic       uart_parity_err;
    logic       uart_framing_err;
    logic       uart_overflow;
`ifdef UART_STREAM_ERRCNT_EN
    logic       err_cnt_clr;
    logic [7:0] perr_cnt;
    logic [7:0] ferr_cnt;
    logic [7:0] ovf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    uart_stream_adapter #(.GUARD_CYCLES(2), .RR_ARB(1'b1)) dut (
        .CLK              (CLK),
        .aresetn          (aresetn),
        .s_tx_data        (s_tx_data),
        .s_tx_valid       (s_tx_valid),
        .s_tx_ready       (s_tx_ready),
        .m_rx_data        (m_rx_data),
        .m_rx_perr        (m_rx_perr),
        .m_rx_ferr        (m_rx_ferr),
        .m_rx_ovf         (m_rx_ovf),
        .m_rx_valid       (m_rx_valid),
        .m_rx_ready       (m_rx_ready),
        .uart_csn         (uart_csn),
        .uart_wen         (uart_wen),
        .uart_oen         (uart_oen),
        .uart_data_in     (uart_data_in),
        .uart_data_out    (uart_data_out),
        .uart_txrdy       (uart_txrdy),
        .uart_rxrdy       (uart_rxrdy),
        .uart_parity_err  (uart_parity_err),
        .uart_framing_err (uart_framing_err),
        .uart_overflow    (uart_overflow)
`ifdef UART_STREAM_ERRCNT_EN
        ,
        .err_cnt_clr      (err_cnt_clr),
        .perr_cnt         (perr_cnt),
        .ferr_cnt         (ferr_cnt),
        .ovf_cnt          (ovf_cnt)
`endif
    );

    // Strobe monitor: samples 1 time unit after each rising edge.
    int         cyc = 0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         both_low = 0;
    logic [7:0] last_wr_data = 8'd0;
    int         ev_cyc[$];
    bit         ev_wr[$];

    always @(posedge CLK) begin
        #1;
        cyc++;
        if (!uart_csn && !uart_wen) begin
            wr_cnt++;
            last_wr_data = uart_data_in;
            ev_cyc.push_back(cyc);
            ev_wr.push_back(1'b1);
        end
        if (!uart_csn && !uart_oen) begin
            rd_cnt++;
            ev_cyc.push_back(cyc);
            ev_wr.push_back(1'b0);
        end
        if (!uart_wen && !uart_oen) both_low++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push(input logic [7:0] d);
        s_tx_data  = d;
        s_tx_valid = 1'b1;
        @(negedge CLK);
        s_tx_valid = 1'b0;
    endtask

    task automatic wait_cnt(input string tag, input bit is_wr, input int target, input int budget);
        int n = 0;
        while (((is_wr ? wr_cnt : rd_cnt) < target) && (n < budget)) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, 32'((is_wr ? wr_cnt : rd_cnt) >= target), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        int n;
        int last;

        aresetn          = 1'b0;
        s_tx_data        = 8'd0;
        s_tx_valid       = 1'b0;
        m_rx_ready       = 1'b1;
        uart_data_out    = 8'd0;
        uart_txrdy       = 1'b0;
        uart_rxrdy       = 1'b0;
        uart_parity_err  = 1'b0;
        uart_framing_err = 1'b0;
        uart_overflow    = 1'b0;
`ifdef UART_STREAM_ERRCNT_EN
        err_cnt_clr      = 1'b0;
`endif

        // Reset state
        cycles(3);
        chk("rst_csn", uart_csn, 1);
        chk("rst_wen", uart_wen, 1);
        chk("rst_oen", uart_oen, 1);
        chk("rst_data_in", uart_data_in, 0);
        chk("rst_tx_ready", s_tx_ready, 1);
        chk("rst_rx_valid", m_rx_valid, 0);
        chk("rst_rx_data", m_rx_data, 0);
        aresetn    = 1'b1;
        uart_txrdy = 1'b1;

        // TX single byte, exact cycle timing
        base = wr_cnt;
        push(8'hA5);
        chk("tx1_ready_low", s_tx_ready, 0);
        chk("tx1_no_strobe_yet", uart_csn, 1);
        @(negedge CLK);
        chk("tx1_csn", uart_csn, 0);
        chk("tx1_wen", uart_wen, 0);
        chk("tx1_oen", uart_oen, 1);
        chk("tx1_data", uart_data_in, 8'hA5);
        chk("tx1_ready_in_strobe", s_tx_ready, 0);
        @(negedge CLK);
        chk("tx1_csn_release", uart_csn, 1);
        chk("tx1_ready_back", s_tx_ready, 1);
        cycles(4);
        chk("tx1_one_strobe", wr_cnt - base, 1);

        // TX blocked by TXRDY
        uart_txrdy = 1'b0;
        base = wr_cnt;
        push(8'h3C);
        cycles(6);
        chk("txb_no_strobe", wr_cnt - base, 0);
        chk("txb_ready_low", s_tx_ready, 0);
        uart_txrdy = 1'b1;
        wait_cnt("txb_strobe_seen", 1'b1, base + 1, 10);
        chk("txb_data", last_wr_data, 8'h3C);
        cycles(6);
        chk("txb_exactly_one", wr_cnt - base, 1);
        chk("txb_ready_back", s_tx_ready, 1);

        // RX capture with back-pressure
        m_rx_ready      = 1'b0;
        uart_data_out   = 8'h5A;
        uart_parity_err = 1'b1;
        base = rd_cnt;
        uart_rxrdy = 1'b1;
        cycles(10);
        chk("rx_one_read", rd_cnt - base, 1);
        chk("rx_valid", m_rx_valid, 1);
        chk("rx_data", m_rx_data, 8'h5A);
        chk("rx_perr", m_rx_perr, 1);
        chk("rx_ferr", m_rx_ferr, 0);
        chk("rx_ovf", m_rx_ovf, 0);
        uart_data_out    = 8'h11;
        uart_parity_err  = 1'b0;
        uart_framing_err = 1'b1;
        cycles(3);
        chk("rx_stable_data", m_rx_data, 8'h5A);
        chk("rx_stable_read_cnt", rd_cnt - base, 1);
        m_rx_ready = 1'b1;
        wait_cnt("rx_resume", 1'b0, base + 3, 20);
        n = ev_cyc.size();
        chk("rx_resume_gap", ev_cyc[n-1] - ev_cyc[n-2], 3);
        uart_rxrdy = 1'b0;
        cycles(5);
        chk("rx2_data", m_rx_data, 8'h11);
        chk("rx2_ferr", m_rx_ferr, 1);
        chk("rx2_perr", m_rx_perr, 0);
        uart_framing_err = 1'b0;

        // Contention with round-robin arbitration
        k = ev_cyc.size();
        s_tx_data  = 8'h77;
        s_tx_valid = 1'b1;
        uart_rxrdy = 1'b1;
        n = 0;
        while ((ev_cyc.size() < k + 8) && (n < 60)) begin
            @(negedge CLK);
            n++;
        end
        chk("arb_events_seen", 32'(ev_cyc.size() >= k + 8), 1);
        if (ev_cyc.size() >= k + 8) begin
            for (int i = k + 2; i < k + 8; i++) begin
                chk($sformatf("arb_alt_%0d", i - k), 32'(ev_wr[i] != ev_wr[i-1]), 1);
                chk($sformatf("arb_gap_%0d", i - k), ev_cyc[i] - ev_cyc[i-1], 3);
            end
        end
        chk("arb_wr_data", last_wr_data, 8'h77);
        s_tx_valid = 1'b0;
        uart_rxrdy = 1'b0;
        cycles(8);
        chk("never_wen_oen_low", both_low, 0);

        // Reset during a write strobe
        m_rx_ready    = 1'b0;
        uart_data_out = 8'hC3;
        base = rd_cnt;
        uart_rxrdy = 1'b1;
        wait_cnt("rst_prep_read", 1'b0, base + 1, 10);
        uart_rxrdy = 1'b0;
        cycles(4);
        chk("rst_prep_valid", m_rx_valid, 1);
        push(8'h99);
        n = 0;
        while (!(!uart_csn && !uart_wen) && (n < 10)) begin
            @(negedge CLK);
            n++;
        end
        chk("rst_wr_strobe_found", 32'(!uart_csn && !uart_wen), 1);
        aresetn = 1'b0;
        #1;
        chk("rstw_csn", uart_csn, 1);
        chk("rstw_wen", uart_wen, 1);
        chk("rstw_oen", uart_oen, 1);
        chk("rstw_tx_ready", s_tx_ready, 1);
        chk("rstw_rx_valid", m_rx_valid, 0);
        cycles(2);
        aresetn = 1'b1;
        m_rx_ready = 1'b1;

        // Held byte discarded by reset
        uart_txrdy = 1'b0;
        push(8'h42);
        cycles(1);
        chk("disc_held", s_tx_ready, 0);
        aresetn = 1'b0;
        #1;
        chk("disc_ready_after_rst", s_tx_ready, 1);
        @(negedge CLK);
        aresetn = 1'b1;
        base = wr_cnt;
        uart_txrdy = 1'b1;
        cycles(8);
        chk("disc_no_write", wr_cnt - base, 0);

`ifdef UART_STREAM_ERRCNT_EN
        // Saturating parity error counter
        uart_data_out   = 8'h0F;
        uart_parity_err = 1'b1;
        base = rd_cnt;
        uart_rxrdy = 1'b1;
        wait_cnt("cnt_300_reads", 1'b0, base + 300, 1300);
        uart_rxrdy = 1'b0;
        cycles(5);
        chk("cnt_perr_sat", perr_cnt, 8'd255);
        chk("cnt_ferr_zero", ferr_cnt, 8'd0);
        chk("cnt_ovf_zero", ovf_cnt, 8'd0);
        err_cnt_clr = 1'b1;
        @(negedge CLK);
        err_cnt_clr = 1'b0;
        chk("cnt_clr", perr_cnt, 8'd0);
        uart_parity_err = 1'b0;
`endif

        last = checks;
        $display("Simulation finished: %0d checks, %0d errors", last, errors);
        $finish;
    end

endmodule
